nibble_serial_adder_ctrl: RTL and testbench

NIBBLE_SERIAL_ADDER_CTRL -- requirements
Module: nibble_serial_adder_ctrl

---
 rtl/nibble_serial_adder_ctrl.sv | 140 ++++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder/subtractor: one shared 4-bit carry-lookahead slice, one nibble per cycle, LSB first.
// Latency NIBBLES cycles from accept to res_valid; the result holds under res_ready backpressure, and no new request is taken until the result is consumed.
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   sub,
    input  logic                   cin,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   ovf,
    output logic                   busy
);
    localparam int W  = 4 * NIBBLES;
    localparam int KW = $clog2(NIBBLES);
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            c_q, c_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic [KW+1:0]   nib_idx;
    logic [3:0]      slice_a, slice_b, slice_p, slice_g, slice_s;
    logic [4:0]      slice_c;
    logic            accept, last_nib;

    // Shared carry-lookahead slice, fed the nibble selected by k_q.
    always_comb begin
        nib_idx    = {k_q, 2'b00};
        slice_a    = a_q[nib_idx +: 4];
        slice_b    = b_q[nib_idx +: 4];
        slice_p    = slice_a ^ slice_b;
        slice_g    = slice_a & slice_b;
        slice_c    = '0;
        slice_c[0] = c_q;
        for (int i = 0; i < 4; i++) begin
            slice_c[i+1] = slice_g[i] | (slice_p[i] & slice_c[i]);
        end
        slice_s    = slice_p ^ slice_c[3:0];
    end

    assign accept   = start_valid && start_ready;
    assign last_nib = (k_q == K_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)                 state_d = RUN;
            RUN:     if (last_nib)               state_d = DONE;
            DONE:    if (res_valid && res_ready) state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    // start_ready is gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        start_ready = (state_q == IDLE) && rst_n;
        res_valid   = (state_q == DONE);
        busy        = (state_q == RUN) || (state_q == DONE);
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        c_d    = c_q;
        k_d    = k_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    // Subtraction is A + ~B + 1, so the inversion and carry are captured here once.
                    a_d = op_a;
                    b_d = sub ? ~op_b : op_b;
                    c_d = sub ? 1'b1 : cin;
                    k_d = '0;
                end
            end
            RUN: begin
                sum_d[nib_idx +: 4] = slice_s;
                c_d = slice_c[4];
                k_d = k_q + KW'(1);
                if (last_nib) begin
                    cout_d = slice_c[4];
                    ovf_d  = slice_c[3] ^ slice_c[4];
                    k_d    = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= 1'b0;
            k_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            c_q    <= c_d;
            k_q    <= k_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl (NIBBLES=4): scoreboard queue filled by the driver,
// drained by a monitor on every result handshake.
module tb_nibble_serial_adder_ctrl;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] op_a, op_b;
    logic         sub, cin;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] sum;
    logic         cout, ovf, busy;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    nibble_serial_adder_ctrl #(.NIBBLES(NIB)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .op_a(op_a), .op_b(op_b), .sub(sub), .cin(cin),
        .res_valid(res_valid), .res_ready(res_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a handshake is seen at the negedge before the edge that completes it.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'(res_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sum",  32'(sum),  32'(e.sum));
                chk("cout", 32'(cout), 32'(e.cout));
                chk("ovf",  32'(ovf),  32'(e.ovf));
            end
        end
    end

    // Present a request one cycle after the previous result; returns after accept edge (+#1).
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic ci,
                         input logic [W-1:0] es, input logic ec, input logic eo, input bit push);
        int n;
        n = 0;
        while (!start_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("start_ready_before_issue", 32'(start_ready), 32'd1);
        op_a = a; op_b = b; sub = s; cin = ci; start_valid = 1'b1;
        if (push) exp_q.push_back('{sum: es, cout: ec, ovf: eo});
        @(posedge clk); #1;
        start_valid = 1'b0;
        // Scramble inputs: the operation must use the captured operands only.
        op_a = W'($urandom); op_b = W'($urandom); sub = ~s; cin = ~ci;
    endtask

    // Count cycles from accept until res_valid; checks the NIBBLES-cycle latency.
    task automatic wait_result(input string name);
        int n;
        n = 0;
        while (!res_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk(name, 32'(n), 32'(NIB));
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic ci,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        issue(a, b, s, ci, es, ec, eo, 1'b1);
        wait_result(name);
        @(posedge clk); #1;
        chk("ready_after_handshake", 32'(start_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b1;
        op_a = '0; op_b = '0; sub = 1'b0; cin = 1'b0;
        #2;
        chk("rst_sum",        32'(sum),         32'd0);
        chk("rst_res_valid",  32'(res_valid),   32'd0);
        chk("rst_busy",       32'(busy),        32'd0);
        chk("rst_cout_ovf",   32'({cout, ovf}), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_start_ready", 32'(start_ready), 32'd1);

        run_op("lat_00ff_0001", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        run_op("lat_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("lat_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("lat_sub_5_7",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("lat_sub_8000_1",16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        run_op("lat_add_cin",   16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0);
        chk("idle_retains_sum", 32'(sum), 32'h5556);

        // Backpressure: hold res_ready low three cycles while hammering the inputs.
        res_ready = 1'b0;
        issue(16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        wait_result("lat_bp");
        for (int i = 0; i < 3; i++) begin
            start_valid = 1'b1; op_a = W'($urandom); op_b = W'($urandom); sub = i[0]; cin = ~i[0];
            @(posedge clk); #1;
            chk("bp_sum",         32'(sum),         32'h0000);
            chk("bp_cout_ovf",    32'({cout, ovf}), 32'h2);
            chk("bp_res_valid",   32'(res_valid),   32'd1);
            chk("bp_start_ready", 32'(start_ready), 32'd0);
        end
        // Handshake cycle with a new request already waiting; it must be taken one cycle later.
        op_a = 16'h0003; op_b = 16'h0004; sub = 1'b0; cin = 1'b0; start_valid = 1'b1;
        exp_q.push_back('{sum: 16'h0007, cout: 1'b0, ovf: 1'b0});
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("hs_busy_clear",   32'(busy),        32'd0);
        chk("hs_start_ready",  32'(start_ready), 32'd1);
        @(posedge clk); #1;
        start_valid = 1'b0;
        chk("next_accepted", 32'(busy), 32'd1);
        wait_result("lat_after_bp");
        @(posedge clk); #1;

        // Abort mid-operation with reset: nothing may be produced.
        issue(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_sum",        32'(sum),         32'd0);
        chk("abort_flags",      32'({cout, ovf}), 32'd0);
        chk("abort_res_valid",  32'(res_valid),   32'd0);
        chk("abort_busy",       32'(busy),        32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_result", 32'(res_valid), 32'd0);
        run_op("lat_after_abort", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
